// File: rtl/out_buffer_vc_pkg.sv
// Shared parameters and helpers for the NoC virtual-channel output buffer.
// Width math and pointer wrap live here so the FIFO and top agree on them.
package noc_buf_pkg;

  localparam int DEF_FLIT_W = 67;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int vc_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // Explicit wrap so non-power-of-2 depths never reach an out-of-range slot.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/out_buffer_vc_if.sv
// Crossbar-side write port, downstream stall and link-side outputs of the buffer.
interface out_buffer_vc_if #(
  parameter int FLIT_W = noc_buf_pkg::DEF_FLIT_W,
  parameter int NUM_VC = 2
);
  localparam int VC_W = noc_buf_pkg::vc_width(NUM_VC);

  logic              write;
  logic [VC_W-1:0]   wr_vc;
  logic [FLIT_W-1:0] data_in;
  logic [NUM_VC-1:0] stall_in;
  logic [FLIT_W-1:0] flit_out;
  logic [VC_W-1:0]   vc_out;
  logic              valid_out;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] almost_full;
  logic              overflow;

  modport master (
    output write, wr_vc, data_in, stall_in,
    input  flit_out, vc_out, valid_out, full, almost_full, overflow
  );

  modport slave (
    input  write, wr_vc, data_in, stall_in,
    output flit_out, vc_out, valid_out, full, almost_full, overflow
  );
endinterface

// File: rtl/out_buffer_vc_vc_fifo.sv
// One virtual-channel circular FIFO with occupancy count and full/almost-full flags.
module vc_fifo
  import noc_buf_pkg::*;
#(
  parameter int FLIT_W    = DEF_FLIT_W,
  parameter int DEPTH     = 6,
  parameter int AFULL_LVL = 5,
  localparam int CNT_W    = clog2(DEPTH + 1),
  localparam int PTR_W    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [FLIT_W-1:0] wr_data,
  output logic [FLIT_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  count_nxt,
  output logic              full,
  output logic              afull
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;

  always_comb begin
    count_nxt = count;
    if (rd_en && !wr_en)
      count_nxt = count - 1'b1;
    else if (wr_en && !rd_en)
      count_nxt = count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= PTR_W'(ptr_next(int'(wr_ptr), DEPTH));
      end
      if (rd_en)
        rd_ptr <= PTR_W'(ptr_next(int'(rd_ptr), DEPTH));
      count <= count_nxt;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign afull = (count >= CNT_W'(AFULL_LVL));

endmodule

// File: rtl/out_buffer_vc.sv
// NoC router output buffer: NUM_VC independent FIFOs behind a registered
// round-robin selector that presents one head flit per cycle on the link.
module out_buffer_vc
  import noc_buf_pkg::*;
#(
  parameter int FLIT_W    = DEF_FLIT_W,
  parameter int DEPTH     = 6,
  parameter int NUM_VC    = 2,
  parameter int AFULL_LVL = 5,
  localparam int VC_W     = vc_width(NUM_VC),
  localparam int CNT_W    = clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  out_buffer_vc_if.slave bus
);

  logic [NUM_VC-1:0] wr_en, rd_en, fifo_full, fifo_afull;
  logic [CNT_W-1:0]  cnt     [NUM_VC];
  logic [CNT_W-1:0]  cnt_nxt [NUM_VC];
  logic [FLIT_W-1:0] head    [NUM_VC];
  logic [VC_W-1:0]   cur_vc, cur_vc_nxt;
  logic              valid, xfer, vc_in_range, drop, ovf, hold, found;
  int                sel_idx;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo #(
      .FLIT_W   (FLIT_W),
      .DEPTH    (DEPTH),
      .AFULL_LVL(AFULL_LVL)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[v]),
      .rd_en    (rd_en[v]),
      .wr_data  (bus.data_in),
      .head     (head[v]),
      .count    (cnt[v]),
      .count_nxt(cnt_nxt[v]),
      .full     (fifo_full[v]),
      .afull    (fifo_afull[v])
    );
  end

  assign valid       = (cnt[cur_vc] != '0);
  assign xfer        = valid && !bus.stall_in[cur_vc];
  assign vc_in_range = ({1'b0, bus.wr_vc} < (VC_W + 1)'(NUM_VC));

  // A full VC still accepts a write when its head leaves in the same cycle.
  always_comb begin
    rd_en = '0;
    wr_en = '0;
    drop  = 1'b0;
    if (xfer) rd_en[cur_vc] = 1'b1;
    if (bus.write && vc_in_range) begin
      if (!fifo_full[bus.wr_vc] || rd_en[bus.wr_vc])
        wr_en[bus.wr_vc] = 1'b1;
      else
        drop = 1'b1;
    end
  end

  // Search starts one past the current VC so the current one is checked last.
  always_comb begin
    cur_vc_nxt = cur_vc;
    found      = 1'b0;
    sel_idx    = 0;
    hold       = (cnt_nxt[cur_vc] != '0) && !bus.stall_in[cur_vc] && !xfer;
    if (!hold) begin
      for (int i = 1; i <= NUM_VC; i++) begin
        sel_idx = (int'(cur_vc) + i) % NUM_VC;
        if (!found && (cnt_nxt[sel_idx] != '0) && !bus.stall_in[sel_idx]) begin
          cur_vc_nxt = VC_W'(sel_idx);
          found      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_vc <= '0;
      ovf    <= 1'b0;
    end else begin
      cur_vc <= cur_vc_nxt;
      if (drop) ovf <= 1'b1;
    end
  end

  assign bus.flit_out    = head[cur_vc];
  assign bus.vc_out      = cur_vc;
  assign bus.valid_out   = valid;
  assign bus.full        = fifo_full;
  assign bus.almost_full = fifo_afull;
  assign bus.overflow    = ovf;

endmodule

// File: tb/tb_out_buffer_vc.sv
// Self-checking bench for out_buffer_vc: directed scenarios plus random traffic
// compared against a queue-based reference model of the buffer.
module tb_out_buffer_vc;
  localparam int FLIT_W    = 67;
  localparam int DEPTH     = 6;
  localparam int NUM_VC    = 2;
  localparam int AFULL_LVL = 5;
  localparam int VC_W      = noc_buf_pkg::vc_width(NUM_VC);
  localparam int STAT_W    = 2 + VC_W + 2 * NUM_VC;

  typedef logic [FLIT_W-1:0] flit_q_t[$];

  logic clk, rst;
  int   ncmp, nfail;

  flit_q_t q [NUM_VC];
  int      m_cur;
  logic    m_ovf;

  out_buffer_vc_if #(.FLIT_W(FLIT_W), .NUM_VC(NUM_VC)) bus ();

  out_buffer_vc #(
    .FLIT_W(FLIT_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC), .AFULL_LVL(AFULL_LVL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [STAT_W-1:0] dut_stat();
    return {bus.valid_out, bus.vc_out, bus.full, bus.almost_full, bus.overflow};
  endfunction

  function automatic logic [STAT_W-1:0] exp_stat();
    logic [NUM_VC-1:0] f, af;
    f  = '0;
    af = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      f[v]  = (q[v].size() == DEPTH);
      af[v] = (q[v].size() >= AFULL_LVL);
    end
    return {q[m_cur].size() != 0, VC_W'(m_cur), f, af, m_ovf};
  endfunction

  task automatic model_clear();
    for (int v = 0; v < NUM_VC; v++) q[v].delete();
    m_cur = 0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of the buffer as described behaviourally: pop the granted
  // head, append an accepted write, then choose the next VC round-robin.
  task automatic model_step();
    bit xfer, hold;
    int wv, v;
    xfer = (q[m_cur].size() != 0) && !bus.stall_in[m_cur];
    if (xfer) void'(q[m_cur].pop_front());
    if (bus.write) begin
      wv = int'(bus.wr_vc);
      if (wv < NUM_VC) begin
        if (q[wv].size() < DEPTH) q[wv].push_back(bus.data_in);
        else m_ovf = 1'b1;
      end
    end
    hold = (q[m_cur].size() != 0) && !bus.stall_in[m_cur] && !xfer;
    if (!hold) begin
      for (int k = 1; k <= NUM_VC; k++) begin
        v = (m_cur + k) % NUM_VC;
        if (q[v].size() != 0 && !bus.stall_in[v]) begin
          m_cur = v;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write    = 1'b0;
    bus.wr_vc    = '0;
    bus.data_in  = '0;
    bus.stall_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #3 rst = 1'b0;
    model_clear();
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int vc, input int n, input logic [FLIT_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.write   = 1'b1;
      bus.wr_vc   = VC_W'(vc);
      bus.data_in = base + FLIT_W'(i);
      tick();
    end
    bus.write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    model_clear();
    #12 rst = 1'b1;
    @(posedge clk);
    #1;
    ncmp++;
    if (dut_stat() !== '0) begin
      nfail++;
      $display("FAIL reset_status: got %h want 0", dut_stat());
    end
    ncmp++;
    if (bus.flit_out !== '0) begin
      nfail++;
      $display("FAIL reset_flit: got %h want 0", bus.flit_out);
    end
  endtask

  task automatic test_fill_drain();
    bus.stall_in = 2'b01;
    load(0, DEPTH, FLIT_W'(1));
    ncmp++;
    if (bus.full[0] !== 1'b1 || bus.flit_out !== FLIT_W'(1)) begin
      nfail++;
      $display("FAIL fill_full: got full=%b head=%h want full=1 head=1", bus.full, bus.flit_out);
    end
    bus.stall_in = '0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tick();
      ncmp++;
      if (dut_stat() !== exp_stat()) begin
        nfail++;
        $display("FAIL drain_status: step %0d got %h want %h", i, dut_stat(), exp_stat());
      end
      if (i < DEPTH - 1) begin
        ncmp++;
        if (bus.flit_out !== FLIT_W'(i + 2) || bus.vc_out !== '0) begin
          nfail++;
          $display("FAIL drain_order: step %0d got %h/vc%0d want %h/vc0", i, bus.flit_out, bus.vc_out, i + 2);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.stall_in = 2'b01;
    load(0, DEPTH, FLIT_W'(1));
    bus.write   = 1'b1;
    bus.wr_vc   = '0;
    bus.data_in = FLIT_W'(7);
    tick();
    bus.write = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i == 2) bus.stall_in = '0;
      tick();
      ncmp++;
      if (dut_stat() !== exp_stat()) begin
        nfail++;
        $display("FAIL overflow_status: step %0d got %h want %h", i, dut_stat(), exp_stat());
      end
      if (q[m_cur].size() != 0) begin
        ncmp++;
        if (bus.flit_out !== q[m_cur][0]) begin
          nfail++;
          $display("FAIL overflow_data: step %0d got %h want %h", i, bus.flit_out, q[m_cur][0]);
        end
      end
    end
    ncmp++;
    if (bus.overflow !== 1'b1) begin
      nfail++;
      $display("FAIL overflow_sticky: got %b want 1", bus.overflow);
    end
  endtask

  task automatic test_write_on_full_read();
    do_reset();
    bus.stall_in = 2'b01;
    load(0, DEPTH, FLIT_W'(1));
    bus.stall_in = '0;
    bus.write    = 1'b1;
    bus.wr_vc    = '0;
    bus.data_in  = FLIT_W'(7);
    tick();
    bus.write = 1'b0;
    ncmp++;
    if (bus.full[0] !== 1'b1 || bus.overflow !== 1'b0 || bus.flit_out !== FLIT_W'(2)) begin
      nfail++;
      $display("FAIL wfr_accept: got full=%b ovf=%b head=%h want 1 0 2",
               bus.full[0], bus.overflow, bus.flit_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ncmp++;
      if (bus.flit_out !== FLIT_W'(i + 2) || bus.valid_out !== 1'b1) begin
        nfail++;
        $display("FAIL wfr_order: step %0d got %h v=%b want %h v=1", i, bus.flit_out, bus.valid_out, i + 2);
      end
      tick();
    end
    ncmp++;
    if (dut_stat() !== exp_stat()) begin
      nfail++;
      $display("FAIL wfr_empty: got %h want %h", dut_stat(), exp_stat());
    end
  endtask

  task automatic test_round_robin();
    logic [FLIT_W-1:0] seq [6];
    do_reset();
    bus.stall_in = 2'b11;
    load(0, 3, FLIT_W'('hA0));
    load(1, 3, FLIT_W'('hB0));
    seq = '{FLIT_W'('hA0), FLIT_W'('hB0), FLIT_W'('hA1), FLIT_W'('hB1), FLIT_W'('hA2), FLIT_W'('hB2)};
    bus.stall_in = '0;
    for (int i = 0; i < 6; i++) begin
      ncmp++;
      if (bus.flit_out !== seq[i] || bus.vc_out !== VC_W'(i % 2) || bus.valid_out !== 1'b1) begin
        nfail++;
        $display("FAIL rr_order: step %0d got %h/vc%0d want %h/vc%0d", i, bus.flit_out, bus.vc_out, seq[i], i % 2);
      end
      tick();
    end
    ncmp++;
    if (dut_stat() !== exp_stat()) begin
      nfail++;
      $display("FAIL rr_final: got %h want %h", dut_stat(), exp_stat());
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.stall_in = 2'b11;
    load(0, 3, FLIT_W'('hA0));
    load(1, 3, FLIT_W'('hB0));
    bus.stall_in = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      ncmp++;
      if (dut_stat() !== exp_stat() || q[0].size() != 3) begin
        nfail++;
        $display("FAIL stall_status: step %0d got %h want %h", i, dut_stat(), exp_stat());
      end
    end
    bus.stall_in = '0;
    tick();
    ncmp++;
    if (bus.vc_out !== '0 || bus.valid_out !== 1'b1 || bus.flit_out !== FLIT_W'('hA0)) begin
      nfail++;
      $display("FAIL stall_resume: got %h/vc%0d v=%b want a0/vc0 v=1", bus.flit_out, bus.vc_out, bus.valid_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.write    = ($urandom_range(0, 9) < 6);
      bus.wr_vc    = VC_W'($urandom_range(0, NUM_VC - 1));
      bus.data_in  = FLIT_W'({$urandom(), $urandom(), $urandom()});
      bus.stall_in = ($urandom_range(0, 2) == 0) ? NUM_VC'($urandom()) : '0;
      tick();
      ncmp++;
      if (dut_stat() !== exp_stat()) begin
        nfail++;
        $display("FAIL random_status: cycle %0d got %h want %h", i, dut_stat(), exp_stat());
      end
      if (q[m_cur].size() != 0) begin
        ncmp++;
        if (bus.flit_out !== q[m_cur][0]) begin
          nfail++;
          $display("FAIL random_data: cycle %0d got %h want %h", i, bus.flit_out, q[m_cur][0]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.stall_in = 2'b01;
    load(0, 3, FLIT_W'('h11));
    bus.write    = 1'b1;
    bus.wr_vc    = '0;
    bus.data_in  = FLIT_W'('h55);
    ncmp++;
    if (bus.valid_out !== 1'b1 || bus.flit_out !== FLIT_W'('h11)) begin
      nfail++;
      $display("FAIL midrst_pre: got v=%b %h want v=1 11", bus.valid_out, bus.flit_out);
    end
    #2 rst = 1'b0;
    #1;
    model_clear();
    ncmp++;
    if (dut_stat() !== '0 || bus.flit_out !== '0) begin
      nfail++;
      $display("FAIL midrst_clear: got %h flit %h want 0 0", dut_stat(), bus.flit_out);
    end
    idle_inputs();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    bus.write   = 1'b1;
    bus.wr_vc   = VC_W'(1);
    bus.data_in = FLIT_W'('hABC);
    ncmp++;
    if (bus.valid_out !== 1'b0) begin
      nfail++;
      $display("FAIL midrst_latency: got valid=%b want 0", bus.valid_out);
    end
    tick();
    bus.write = 1'b0;
    ncmp++;
    if (bus.valid_out !== 1'b1 || bus.vc_out !== VC_W'(1) || bus.flit_out !== FLIT_W'('hABC)) begin
      nfail++;
      $display("FAIL midrst_write: got v=%b vc%0d %h want v=1 vc1 abc", bus.valid_out, bus.vc_out, bus.flit_out);
    end
  endtask

  initial begin
    ncmp  = 0;
    nfail = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_write_on_full_read();
    test_round_robin();
    test_stall();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
